// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined opcode decoder with load-use, MUL occupancy and JAL flush control
//
// Decodes the ID-stage opcode into a control bundle and carries it through the
// EX, MEM and WB stage registers. It also drives stall and flush back to the
// front end.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   id_valid, id_op                 ID-stage instruction valid and opcode
//   id_rs1, id_rs2, id_rd           ID-stage register indices
//   ex_alu_src, ex_alu_op           EX-stage ALU controls (registered)
//   mem_read, mem_write             MEM-stage load/store enables (registered)
//   wb_mem_to_reg, wb_reg_write     WB-stage result select and write enable (registered)
//   wb_rd                           WB-stage destination (registered)
//   pc_src, flush                   jump redirect and IF/ID squash (from EX state)
//   stall                           hold PC and IF/ID (from EX state and ID inputs)
//   mul_busy                        MUL occupying EX beyond its first cycle
module ctrl_pipe #(
  parameter int OP_W    = 8,
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_op,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  output logic [1:0]       ex_alu_src,
  output logic [3:0]       ex_alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       wb_mem_to_reg,
  output logic             wb_reg_write,
  output logic [REG_W-1:0] wb_rd,
  output logic             pc_src,
  output logic             flush,
  output logic             stall,
  output logic             mul_busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(8'h18);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(8'h19);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(8'h31);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(8'h04);

  typedef struct packed {
    logic             valid;
    logic [1:0]       alu_src;
    logic [3:0]       alu_op;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             jal;
    logic             mul;
    logic [REG_W-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic             valid;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic             valid;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } wb_t;

  ex_t              dec;
  ex_t              ex_d,  ex_q;
  mem_t             mem_d, mem_q;
  wb_t              wb_d,  wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic mul_busy_c;
  logic load_use_c;
  logic jal_c;

  // ID decode; unknown opcodes and invalid slots become an all-zero bubble.
  always_comb begin
    dec = '0;
    if (id_valid) begin
      case (id_op)
        OP_ADD: begin
          dec.valid     = 1'b1;
          dec.reg_write = 1'b1;
        end
        OP_MUL: begin
          dec.valid     = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = 4'b0010;
          dec.mul       = 1'b1;
        end
        OP_SW: begin
          dec.valid     = 1'b1;
          dec.mem_write = 1'b1;
          dec.alu_src   = 2'b01;
        end
        OP_LW: begin
          dec.valid      = 1'b1;
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 2'b01;
          dec.reg_write  = 1'b1;
          dec.alu_src    = 2'b01;
        end
        OP_JAL: begin
          dec.valid      = 1'b1;
          dec.mem_to_reg = 2'b10;
          dec.reg_write  = 1'b1;
          dec.jal        = 1'b1;
        end
        default: ;
      endcase
      if (dec.valid) dec.rd = id_rd;
      // x0 is hardwired, so writes to it are dropped at decode.
      if (id_rd == '0) dec.reg_write = 1'b0;
    end
  end

  assign mul_busy_c = ex_q.valid && ex_q.mul && (cnt_q != '0);
  // Only LW sets mem_read, so it identifies a load sitting in EX.
  assign load_use_c = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                      ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
  // A JAL is never held in EX, so its single EX cycle is also its first.
  assign jal_c      = ex_q.valid && ex_q.jal;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    mem_d = '0;

    wb_d.valid      = mem_q.valid;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.rd         = mem_q.rd;

    if (mul_busy_c) begin
      // EX holds the MUL and MEM takes a bubble (mem_d stays zero).
      cnt_d = cnt_q - 1'b1;
    end else begin
      mem_d.valid      = ex_q.valid;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.rd         = ex_q.rd;
      if (load_use_c || jal_c) begin
        // Load-use inserts a bubble behind the LW; JAL squashes the ID slot.
        ex_d  = '0;
        cnt_d = '0;
      end else begin
        ex_d  = dec;
        cnt_d = dec.mul ? CNT_LOAD : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;
  assign mem_read      = mem_q.valid && mem_q.mem_read;
  assign mem_write     = mem_q.valid && mem_q.mem_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_reg_write  = wb_q.valid && wb_q.reg_write;
  assign wb_rd         = wb_q.rd;
  assign pc_src        = jal_c;
  assign flush         = jal_c;
  assign stall         = mul_busy_c || load_use_c;
  assign mul_busy      = mul_busy_c;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed self-checking bench for ctrl_pipe
module tb_ctrl_pipe;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 1'b0;
  logic [7:0] id_op = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic [1:0] o_alu_src, p_alu_src;
  logic [3:0] o_alu_op, p_alu_op;
  logic       o_mem_read, o_mem_write, p_mem_read, p_mem_write;
  logic [1:0] o_m2r, p_m2r;
  logic       o_rw, p_rw;
  logic [4:0] o_wb_rd, p_wb_rd;
  logic       o_pc_src, o_flush, o_stall, o_busy;
  logic       p_pc_src, p_flush, p_stall, p_busy;

  ctrl_pipe #(.OP_W(8), .REG_W(5), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_alu_src(o_alu_src), .ex_alu_op(o_alu_op),
    .mem_read(o_mem_read), .mem_write(o_mem_write),
    .wb_mem_to_reg(o_m2r), .wb_reg_write(o_rw), .wb_rd(o_wb_rd),
    .pc_src(o_pc_src), .flush(o_flush), .stall(o_stall), .mul_busy(o_busy)
  );

  ctrl_pipe #(.OP_W(8), .REG_W(5), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_alu_src(p_alu_src), .ex_alu_op(p_alu_op),
    .mem_read(p_mem_read), .mem_write(p_mem_write),
    .wb_mem_to_reg(p_m2r), .wb_reg_write(p_rw), .wb_rd(p_wb_rd),
    .pc_src(p_pc_src), .flush(p_flush), .stall(p_stall), .mul_busy(p_busy)
  );

  int checks = 0;
  int failures = 0;

  // Program presented by the modelled front end.
  logic       pv[32];
  logic [7:0] pop[32];
  logic [4:0] prs1[32], prs2[32], prd[32];
  int n;

  // Model: which program entry occupies each stage (-1 = bubble).
  int m_ex, m_mem, m_wb, m_left, m_p;
  int n_ex, n_mem, n_wb, n_left, n_p;
  logic [1:0] e_alu_src, e_m2r;
  logic [3:0] e_alu_op;
  logic       e_mem_read, e_mem_write, e_rw, e_pc_src, e_flush, e_stall, e_busy;
  logic [4:0] e_wb_rd;

  logic check_en = 1'b0;
  int   cyc;
  int   stall_cnt, busy_cnt, flush_cnt, pc_cnt, memw_seen, any_out, p_stall_cnt, p_busy_cnt;
  logic [4:0] s_wb_rd[64], s1_wb_rd[64];
  logic [1:0] s_m2r[64];
  logic       s_rw[64], s_stall[64], s_busy[64], s_flush[64];
  logic [3:0] s_alu_op[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_ins(input logic v, input logic [7:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
    pv[n] = v; pop[n] = op; prs1[n] = rs1; prs2[n] = rs2; prd[n] = rd;
    n++;
  endtask

  // 0 none, 1 ADD, 2 MUL, 3 SW, 4 LW, 5 JAL
  function automatic int kind(input int i);
    if (i < 0 || i >= n) return 0;
    if (!pv[i]) return 0;
    case (pop[i])
      8'h08: return 1;
      8'h18: return 2;
      8'h19: return 3;
      8'h31: return 4;
      8'h04: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_cycle();
    int ke, km, kw;
    logic busy, lu, jal;
    ke = kind(m_ex); km = kind(m_mem); kw = kind(m_wb);
    busy = (ke == 2) && (m_left > 0);
    lu = (ke == 4) && (prd[m_ex] != 0) && (m_p < n) && pv[m_p] &&
         ((prd[m_ex] == prs1[m_p]) || (prd[m_ex] == prs2[m_p]));
    jal = (ke == 5);
    e_alu_src   = (ke == 3 || ke == 4) ? 2'b01 : 2'b00;
    e_alu_op    = (ke == 2) ? 4'b0010 : 4'b0000;
    e_mem_read  = (km == 4);
    e_mem_write = (km == 3);
    e_m2r       = (kw == 4) ? 2'b01 : (kw == 5) ? 2'b10 : 2'b00;
    e_rw        = (kw == 1 || kw == 2 || kw == 4 || kw == 5) && (prd[m_wb] != 0);
    e_wb_rd     = (kw != 0) ? prd[m_wb] : 5'd0;
    e_pc_src = jal; e_flush = jal; e_stall = busy || lu; e_busy = busy;
    n_wb = m_mem;
    if (busy) begin
      n_mem = -1; n_ex = m_ex; n_left = m_left - 1; n_p = m_p;
    end else begin
      n_mem = m_ex;
      n_ex = (lu || jal || kind(m_p) == 0) ? -1 : m_p;
      n_left = (kind(n_ex) == 2) ? LAT - 1 : 0;
      n_p = (lu || m_p >= n) ? m_p : m_p + 1;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("ex_alu_src", 32'(o_alu_src), 32'(e_alu_src));
      chk("ex_alu_op", 32'(o_alu_op), 32'(e_alu_op));
      chk("mem_read", 32'(o_mem_read), 32'(e_mem_read));
      chk("mem_write", 32'(o_mem_write), 32'(e_mem_write));
      chk("wb_mem_to_reg", 32'(o_m2r), 32'(e_m2r));
      chk("wb_reg_write", 32'(o_rw), 32'(e_rw));
      chk("wb_rd", 32'(o_wb_rd), 32'(e_wb_rd));
      chk("pc_src", 32'(o_pc_src), 32'(e_pc_src));
      chk("flush", 32'(o_flush), 32'(e_flush));
      chk("stall", 32'(o_stall), 32'(e_stall));
      chk("mul_busy", 32'(o_busy), 32'(e_busy));
      s_wb_rd[cyc] = o_wb_rd; s_m2r[cyc] = o_m2r; s_rw[cyc] = o_rw;
      s_stall[cyc] = o_stall; s_busy[cyc] = o_busy; s_flush[cyc] = o_flush;
      s_alu_op[cyc] = o_alu_op; s1_wb_rd[cyc] = p_wb_rd;
      stall_cnt += int'(o_stall); busy_cnt += int'(o_busy);
      flush_cnt += int'(o_flush); pc_cnt += int'(o_pc_src);
      memw_seen += int'(o_mem_write);
      p_stall_cnt += int'(p_stall); p_busy_cnt += int'(p_busy);
      if ({o_alu_src, o_alu_op, o_mem_read, o_mem_write, o_m2r, o_rw, o_wb_rd,
           o_pc_src, o_flush, o_stall, o_busy} != '0) any_out++;
    end
  end

  task automatic chk_zero(input string name);
    chk(name, 32'({o_alu_src, o_alu_op, o_mem_read, o_mem_write, o_m2r, o_rw, o_wb_rd,
                   o_pc_src, o_flush, o_stall, o_busy}), 32'd0);
    chk({name, "_lat1"}, 32'({p_alu_src, p_alu_op, p_mem_read, p_mem_write, p_m2r, p_rw,
                              p_wb_rd, p_pc_src, p_flush, p_stall, p_busy}), 32'd0);
  endtask

  task automatic new_prog();
    n = 0;
    stall_cnt = 0; busy_cnt = 0; flush_cnt = 0; pc_cnt = 0; memw_seen = 0;
    any_out = 0; p_stall_cnt = 0; p_busy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      s_wb_rd[i] = 'x; s_m2r[i] = 'x; s_rw[i] = 'x; s_stall[i] = 'x;
      s_busy[i] = 'x; s_flush[i] = 'x; s_alu_op[i] = 'x; s1_wb_rd[i] = 'x;
    end
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    rst_n = 1'b0;
    id_valid = 1'b0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_outputs");
    #1 rst_n = 1'b1;
  endtask

  task automatic run(input int ncyc);
    m_ex = -1; m_mem = -1; m_wb = -1; m_left = 0; m_p = 0;
    for (int k = 0; k < ncyc; k++) begin
      cyc = k;
      if (m_p < n) begin
        id_valid = pv[m_p]; id_op = pop[m_p];
        id_rs1 = prs1[m_p]; id_rs2 = prs2[m_p]; id_rd = prd[m_p];
      end else begin
        id_valid = 1'b0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      end
      model_cycle();
      check_en = 1'b1;
      @(posedge clk);
      #1;
      m_ex = n_ex; m_mem = n_mem; m_wb = n_wb; m_left = n_left; m_p = n_p;
    end
    check_en = 1'b0;
  endtask

  initial begin
    // ADD rd=3
    do_reset(); new_prog();
    add_ins(1, 8'h08, 5'd1, 5'd2, 5'd3);
    run(6);
    chk("t1_ex_alu_op_c1", 32'(s_alu_op[1]), 32'd0);
    chk("t1_wb_rw_c2", 32'(s_rw[2]), 32'd0);
    chk("t1_wb_rw_c3", 32'(s_rw[3]), 32'd1);
    chk("t1_wb_rd_c3", 32'(s_wb_rd[3]), 32'd3);
    chk("t1_wb_m2r_c3", 32'(s_m2r[3]), 32'd0);
    chk("t1_stalls", 32'(stall_cnt), 32'd0);

    // LW rd=5 then ADD rs1=5
    do_reset(); new_prog();
    add_ins(1, 8'h31, 5'd1, 5'd0, 5'd5);
    add_ins(1, 8'h08, 5'd5, 5'd2, 5'd6);
    run(8);
    chk("t2_stalls", 32'(stall_cnt), 32'd1);
    chk("t2_stall_c1", 32'(s_stall[1]), 32'd1);
    chk("t2_lw_wb_rd_c3", 32'(s_wb_rd[3]), 32'd5);
    chk("t2_lw_wb_m2r_c3", 32'(s_m2r[3]), 32'd1);
    chk("t2_wb_rw_c4", 32'(s_rw[4]), 32'd0);
    chk("t2_add_wb_rd_c5", 32'(s_wb_rd[5]), 32'd6);
    chk("t2_add_wb_rw_c5", 32'(s_rw[5]), 32'd1);

    // LW rd=0 then ADD rs1=0: no hazard
    do_reset(); new_prog();
    add_ins(1, 8'h31, 5'd1, 5'd0, 5'd0);
    add_ins(1, 8'h08, 5'd0, 5'd2, 5'd6);
    run(7);
    chk("t2b_stalls", 32'(stall_cnt), 32'd0);
    chk("t2b_lw_wb_rw_c3", 32'(s_rw[3]), 32'd0);
    chk("t2b_add_wb_rd_c4", 32'(s_wb_rd[4]), 32'd6);

    // LW rd=9 then SW rs2=9: hazard through rs2
    do_reset(); new_prog();
    add_ins(1, 8'h31, 5'd1, 5'd0, 5'd9);
    add_ins(1, 8'h19, 5'd3, 5'd9, 5'd0);
    run(8);
    chk("t2c_stalls", 32'(stall_cnt), 32'd1);

    // MUL rd=7 then ADD rd=2
    do_reset(); new_prog();
    add_ins(1, 8'h18, 5'd1, 5'd2, 5'd7);
    add_ins(1, 8'h08, 5'd3, 5'd4, 5'd2);
    run(9);
    chk("t3_stalls", 32'(stall_cnt), 32'd2);
    chk("t3_busy", 32'(busy_cnt), 32'd2);
    chk("t3_busy_c1", 32'(s_busy[1]), 32'd1);
    chk("t3_busy_c2", 32'(s_busy[2]), 32'd1);
    chk("t3_busy_c3", 32'(s_busy[3]), 32'd0);
    chk("t3_wb_bubble_c3", 32'(s_rw[3]), 32'd0);
    chk("t3_wb_bubble_c4", 32'(s_rw[4]), 32'd0);
    chk("t3_mul_wb_rd_c5", 32'(s_wb_rd[5]), 32'd7);
    chk("t3_mul_wb_rw_c5", 32'(s_rw[5]), 32'd1);
    chk("t3_add_wb_rd_c6", 32'(s_wb_rd[6]), 32'd2);
    chk("t3_lat1_stalls", 32'(p_stall_cnt), 32'd0);
    chk("t3_lat1_busy", 32'(p_busy_cnt), 32'd0);
    chk("t3_lat1_wb_rd_c3", 32'(s1_wb_rd[3]), 32'd7);

    // JAL rd=1, SW (squashed), ADD rd=4
    do_reset(); new_prog();
    add_ins(1, 8'h04, 5'd0, 5'd0, 5'd1);
    add_ins(1, 8'h19, 5'd2, 5'd3, 5'd0);
    add_ins(1, 8'h08, 5'd5, 5'd6, 5'd4);
    run(8);
    chk("t4_flushes", 32'(flush_cnt), 32'd1);
    chk("t4_pc_src", 32'(pc_cnt), 32'd1);
    chk("t4_flush_c1", 32'(s_flush[1]), 32'd1);
    chk("t4_stalls", 32'(stall_cnt), 32'd0);
    chk("t4_sw_mem_write", 32'(memw_seen), 32'd0);
    chk("t4_jal_m2r_c3", 32'(s_m2r[3]), 32'd2);
    chk("t4_jal_rw_c3", 32'(s_rw[3]), 32'd1);
    chk("t4_jal_rd_c3", 32'(s_wb_rd[3]), 32'd1);
    chk("t4_add_rd_c5", 32'(s_wb_rd[5]), 32'd4);

    // Unknown opcode and invalid ADD
    do_reset(); new_prog();
    add_ins(1, 8'hFF, 5'd1, 5'd2, 5'd3);
    add_ins(0, 8'h08, 5'd1, 5'd2, 5'd3);
    run(6);
    chk("t5_outputs_active", 32'(any_out), 32'd0);

    // Reset during MUL cycle 2, then a fresh ADD
    do_reset(); new_prog();
    add_ins(1, 8'h18, 5'd1, 5'd2, 5'd7);
    add_ins(1, 8'h08, 5'd3, 5'd4, 5'd2);
    run(2);
    chk("t6_busy_before_reset", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_async_reset");
    do_reset(); new_prog();
    add_ins(1, 8'h08, 5'd1, 5'd2, 5'd3);
    run(6);
    chk("t6_add_wb_rd_c3", 32'(s_wb_rd[3]), 32'd3);
    chk("t6_add_wb_rw_c3", 32'(s_rw[3]), 32'd1);
    chk("t6_stalls", 32'(stall_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule
